// File: rtl/fric_pkg.sv
// fric_pkg
// Shared constants for the FRIc master arbiter slice.
//   - FRIc packet types (ctyp) seen on the master transaction port.
//   - Arbiter FSM state encoding. These are plain localparams so older
//     tools can use them too.
//   - ctyp_legal(): true for the request types the arbiter may issue.
package fric_pkg;

   localparam logic [3:0] CTYP_WR    = 4'h2;
   localparam logic [3:0] CTYP_RD    = 4'h3;
   localparam logic [3:0] CTYP_WRACK = 4'h4;
   localparam logic [3:0] CTYP_RDACK = 4'h5;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT_WR = 2'd2;
   localparam logic [1:0] ST_WAIT_RD = 2'd3;

   // Only writes and reads can be issued. Ack types and everything else
   // are rejected back to the requester.
   function automatic logic ctyp_legal(input logic [3:0] ctyp);
      return (ctyp == CTYP_WR) || (ctyp == CTYP_RD);
   endfunction

endpackage

// File: rtl/fric_master_arbiter_if.sv
// fric_master_arbiter_if
// Transaction port between the arbiter and the FRIc client master.
//   m_ctyp/m_port/m_addr/m_wdat : request payload (arbiter -> master)
//   m_tstb                      : one-cycle transaction strobe (arbiter -> master)
//   m_trdy                      : master ready; drops while m_tstb is high (master -> arbiter)
//   m_rstb/m_rdat               : read reply strobe and data (master -> arbiter)
// Modports:
//   master : the arbiter's view (it drives the master port)
//   slave  : the FRIc client master's view
interface fric_master_arbiter_if;
   import fric_pkg::*;

   logic [3:0]  m_ctyp;
   logic [3:0]  m_port;
   logic [7:0]  m_addr;
   logic [15:0] m_wdat;
   logic        m_tstb;
   logic        m_trdy;
   logic        m_rstb;
   logic [15:0] m_rdat;

   modport master (
      output m_ctyp, m_port, m_addr, m_wdat, m_tstb,
      input  m_trdy, m_rstb, m_rdat
   );

   modport slave (
      input  m_ctyp, m_port, m_addr, m_wdat, m_tstb,
      output m_trdy, m_rstb, m_rdat
   );

endinterface

// File: rtl/fric_rr_arbiter.sv
// fric_rr_arbiter
// Picks one requester out of a request vector.
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector, one bit per requester
//   adv      : grant is taken this cycle; move the pointer past it
//   any      : at least one request is pending
//   gnt      : index of the winning requester (valid when any=1)
// Build option FRIC_ARB_FIXED_PRI_EN: the lowest index always wins and
// there is no pointer register. Without it the arbiter is round-robin:
// the search starts at pointer p, and a taken grant g sets p to g+1 mod NREQ.
module fric_rr_arbiter
   import fric_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic            any,
   output logic [IDXW-1:0] gnt
);

   assign any = |req;

`ifdef FRIC_ARB_FIXED_PRI_EN

   // Scan from the top down so the lowest set index is the last write.
   always_comb begin
      gnt = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt = IDXW'(i);
         end
      end
   end

   // There is no pointer in this mode, so the advance input and the clock
   // and reset have nothing to drive.
   logic unused_fixed_pri;
   assign unused_fixed_pri = adv ^ clk ^ rst;

`else

   logic [IDXW-1:0] p_q;
   logic [IDXW-1:0] p_d;
   logic            found;
   logic [IDXW-1:0] idx;

   // Search p, p+1, ... wrapping at NREQ; the first pending request wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = IDXW'((int'(p_q) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   always_comb begin
      p_d = p_q;
      if (adv) begin
         p_d = (int'(gnt) == NREQ - 1) ? '0 : gnt + IDXW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

`endif

endmodule

// File: rtl/fric_master_arbiter.sv
// fric_master_arbiter
// Shares one FRIc client master transaction port among NREQ requesters.
// Only one transaction is outstanding at a time. The arbiter issues it,
// waits for the write ack or read reply, and then pulses req_done to the
// requester that was granted.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   req_valid[NREQ]  : level request; held until its req_done
//   req_ctyp/port/addr/wdat : packed per-requester payload (4/4/8/16 bits each)
//   req_done[NREQ]   : one-cycle completion pulse to the granted requester
//   req_err          : qualifies req_done; request rejected (illegal ctyp)
//   req_rdat         : read data; updated with req_done of a read, held otherwise
//   arb_busy         : high whenever the FSM is not idle
//   m                : master port (fric_master_arbiter_if.master)
// Build option FRIC_ARB_FIXED_PRI_EN selects fixed priority; the default
// is round-robin. The option is handled inside fric_rr_arbiter.
module fric_master_arbiter
   import fric_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [4*NREQ-1:0]  req_ctyp,
   input  logic [4*NREQ-1:0]  req_port,
   input  logic [8*NREQ-1:0]  req_addr,
   input  logic [16*NREQ-1:0] req_wdat,
   output logic [NREQ-1:0]    req_done,
   output logic               req_err,
   output logic [15:0]        req_rdat,
   output logic               arb_busy,
   fric_master_arbiter_if.master m
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Per-requester views of the packed payload buses.
   logic [3:0]  ctyp_arr [NREQ];
   logic [3:0]  port_arr [NREQ];
   logic [7:0]  addr_arr [NREQ];
   logic [15:0] wdat_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign ctyp_arr[gi] = req_ctyp[gi*4 +: 4];
      assign port_arr[gi] = req_port[gi*4 +: 4];
      assign addr_arr[gi] = req_addr[gi*8 +: 8];
      assign wdat_arr[gi] = req_wdat[gi*16 +: 16];
   end

   logic            any_req;
   logic [IDXW-1:0] gnt_idx;
   logic            arb_adv;

   fric_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_valid),
      .adv (arb_adv),
      .any (any_req),
      .gnt (gnt_idx)
   );

   logic [3:0]  sel_ctyp;
   assign sel_ctyp = ctyp_arr[gnt_idx];

   logic [1:0]      state_q,  state_d;
   logic [IDXW-1:0] gnt_q,    gnt_d;
   logic [3:0]      m_ctyp_q, m_ctyp_d;
   logic [3:0]      m_port_q, m_port_d;
   logic [7:0]      m_addr_q, m_addr_d;
   logic [15:0]     m_wdat_q, m_wdat_d;
   logic            m_tstb_q, m_tstb_d;
   logic [NREQ-1:0] done_q,   done_d;
   logic            err_q,    err_d;
   logic [15:0]     rdat_q,   rdat_d;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      m_ctyp_d = m_ctyp_q;
      m_port_d = m_port_q;
      m_addr_d = m_addr_q;
      m_wdat_d = m_wdat_q;
      m_tstb_d = 1'b0;
      done_d   = '0;
      err_d    = 1'b0;
      rdat_d   = rdat_q;
      arb_adv  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A grant is only taken while the master can accept it.
            // A rejected request still moves the pointer so a requester
            // that keeps sending a bad ctyp cannot starve the others.
            if (any_req && m.m_trdy) begin
               arb_adv = 1'b1;
               gnt_d   = gnt_idx;
               if (ctyp_legal(sel_ctyp)) begin
                  m_ctyp_d = sel_ctyp;
                  m_port_d = port_arr[gnt_idx];
                  m_addr_d = addr_arr[gnt_idx];
                  m_wdat_d = wdat_arr[gnt_idx];
                  m_tstb_d = 1'b1;
                  state_d  = ST_ISSUE;
               end else begin
                  done_d[gnt_idx] = 1'b1;
                  err_d           = 1'b1;
               end
            end
         end

         ST_ISSUE: begin
            state_d = (m_ctyp_q == CTYP_RD) ? ST_WAIT_RD : ST_WAIT_WR;
         end

         ST_WAIT_WR: begin
            if (m.m_trdy) begin
               done_d[gnt_q] = 1'b1;
               state_d       = ST_IDLE;
            end
         end

         ST_WAIT_RD: begin
            // For a read, m_trdy comes back one cycle before the reply.
            // Only the reply strobe completes the read.
            if (m.m_rstb) begin
               rdat_d        = m.m_rdat;
               done_d[gnt_q] = 1'b1;
               state_d       = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         m_ctyp_q <= '0;
         m_port_q <= '0;
         m_addr_q <= '0;
         m_wdat_q <= '0;
         m_tstb_q <= 1'b0;
         done_q   <= '0;
         err_q    <= 1'b0;
         rdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         m_ctyp_q <= m_ctyp_d;
         m_port_q <= m_port_d;
         m_addr_q <= m_addr_d;
         m_wdat_q <= m_wdat_d;
         m_tstb_q <= m_tstb_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdat_q   <= rdat_d;
      end
   end

   assign m.m_ctyp = m_ctyp_q;
   assign m.m_port = m_port_q;
   assign m.m_addr = m_addr_q;
   assign m.m_wdat = m_wdat_q;
   assign m.m_tstb = m_tstb_q;

   assign req_done = done_q;
   assign req_err  = err_q;
   assign req_rdat = rdat_q;
   assign arb_busy = (state_q != ST_IDLE);

endmodule

// File: doc/fric_master_arbiter.md
# fric_master_arbiter

Shares one FRIc master transaction port (the ctyp/port/addr/wdat/tstb/trdy/rstb/rdat interface of the FRIc client master) among NREQ local requesters. Each requester presents a read or write request. The arbiter grants one at a time, issues it to the master, waits for the write ack or read reply, and returns a completion pulse plus read data to the granted requester. The block sits between internal register agents and the master, which in turn drives the FRIc byte link.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request; level, held until its req_done
- req_ctyp  in  4*NREQ  packet type per requester; 4'h2 write, 4'h3 read
- req_port  in  4*NREQ  destination port per requester
- req_addr  in  8*NREQ  register address per requester
- req_wdat  in  16*NREQ  write data per requester
- req_done  out  NREQ  one-cycle completion pulse to the granted requester
- req_err  out  1  qualifies req_done: request rejected (illegal ctyp)
- req_rdat  out  16  read data; valid with req_done for reads, holds otherwise
- arb_busy  out  1  high whenever state != IDLE
- m_ctyp, m_port  out  4 each  to master
- m_addr  out  8  to master
- m_wdat  out  16  to master
- m_tstb  out  1  transaction strobe to master
- m_trdy  in  1  master ready (combinational in master, drops while m_tstb is high)
- m_rstb  in  1  master read-reply strobe
- m_rdat  in  16  master read data

## Operation
- FSM states: IDLE, ISSUE, WAIT_WR, WAIT_RD.
- IDLE: if any req_valid and m_trdy==1, pick winner g, latch g and its payload into m_* registers.
  - ctyp 4'h2 → ISSUE, set m_tstb<=1.
  - ctyp 4'h3 → ISSUE, set m_tstb<=1.
  - Other ctyp → stay IDLE, next cycle req_done[g]=1 and req_err=1; master untouched.
- ISSUE: m_tstb<=0; next WAIT_WR or WAIT_RD per latched ctyp.
- WAIT_WR: on m_trdy==1 → req_done[g]<=1 (req_err 0), go IDLE.
- WAIT_RD: ignore m_trdy, which rises one cycle before m_rstb. On m_rstb==1 → req_rdat<=m_rdat, req_done[g]<=1, go IDLE.
- Arbitration default is round-robin. Pointer p starts at 0; search p, p+1, … mod NREQ. After a grant, p<=g+1 mod NREQ. Wrap from NREQ-1 to 0.
- Payload is captured at grant. Later changes to a requester's req_* inputs and deassertion of req_valid after grant are ignored; req_done still pulses.
- A requester may reassert or keep req_valid in the cycle after req_done; that counts as a new request.
- m_ctyp/port/addr/wdat hold their last value outside ISSUE.

## Timing
- Reset values: state IDLE, p=0, m_tstb=0, m_ctyp/m_port/m_addr/m_wdat=0, req_done=0, req_err=0, req_rdat=0, arb_busy=0.
- Grant decision cycle T (IDLE, m_trdy=1) → m_tstb high exactly in cycle T+1, for one cycle.
- Completion detected in cycle C → req_done high in C+1; state is IDLE in C+1.
- A new grant can occur no earlier than C+1, so back-to-back issues have at least 2 idle cycles between m_tstb pulses.
- Reject path: req_done/req_err high at T+1; next grant possible at T+1.
- Reset in any state returns to IDLE next cycle with no req_done. Master shares rst, so in-flight transactions are abandoned.
- m_trdy low in IDLE means no grant; requests wait with no timeout.

## Configuration
- FRIC_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins; pointer logic is removed.
- Undefined: round-robin as above.

## Structure
- Shared package fric_pkg holds:
  - ctyp constants: CTYP_WR=4'h2, CTYP_RD=4'h3, CTYP_WRACK=4'h4, CTYP_RDACK=4'h5
  - arbiter state encoding.
- Sub-module fric_rr_arbiter: request vector in, grant index out, owns the pointer register, honours FRIC_ARB_FIXED_PRI_EN.

## Test plan
- Single write: req 0 ctyp 2, port 1, addr 0x10, wdat 0xBEEF → one m_tstb pulse with those values; req_done[0] one cycle after m_trdy returns high; req_err 0.
- Single read: req 2 ctyp 3, addr 0x20; master returns 0x1234 → req_done[2] the cycle after m_rstb, req_rdat=0x1234; the m_trdy rise one cycle earlier does not complete the read.
- Contention, all 4 requesters valid continuously → grants 0,1,2,3,0 (round-robin). With FRIC_ARB_FIXED_PRI_EN → grants 0,0,0 while req 0 stays valid.
- Illegal ctyp 4'h7 on req 1 → req_done[1] and req_err high at T+1; m_tstb never asserts.
- Requests pending while m_trdy held low for 10 cycles → no m_tstb; grant occurs the cycle m_trdy rises.
- rst asserted in WAIT_RD → IDLE, m_tstb=0, no req_done, p=0 after reset.
